// File: rtl/link_receiver.sv
// link_receiver: folded-link packet receiver with a DEPTH-entry packet queue.
//
// Each beat carries GATE_FOLDS flits. Slot 0 occupies the MSB flit of i_w_rx.
// A packet starts with HEADER_FLITS header flits, which hold the one-flag,
// the per-gate valids and the per-gate credits. The header is followed by one
// payload flit per valid gate, packed with no gaps. Each complete packet is
// written to the queue. A packet that arrives while the queue is full is
// consumed and discarded, and o_drop pulses on its last beat.
//
// Ports:
//   i_clk, i_rst    clock, asynchronous active-low reset
//   i_w_enable      marks the header beat of a packet (ignored mid-packet)
//   i_w_rx          beat data, slot k at [FLIT_WIDTH*(GATE_FOLDS-k)-1 -: FLIT_WIDTH]
//   i_r_pull        pop the head packet (ignored when the queue is empty)
//   o_r_available   queue non-empty
//   o_r_vl/cr/dt    head packet valids, credits and data (zero when empty)
//   o_full          queue holds DEPTH packets
//   o_drop          pulse on the last beat of a discarded packet
//   o_err_sof       (RX_SOF_CHECK_EN only) pulse on a header beat whose one-flag is 0
//
// Optional feature macro: RX_SOF_CHECK_EN. When it is defined, a header whose
// one-flag is 0 causes the packet to be dropped and o_err_sof to be reported.
module link_receiver #(
  parameter int FLIT_WIDTH = 8,
  parameter int GATE_WIDTH = 4,
  parameter int GATE_FOLDS = 2,
  parameter int DEPTH      = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_w_enable,
  input  logic [FLIT_WIDTH*GATE_FOLDS-1:0] i_w_rx,
  input  logic                             i_r_pull,
  output logic                             o_r_available,
  output logic [GATE_WIDTH-1:0]            o_r_vl,
  output logic [GATE_WIDTH-1:0]            o_r_cr,
  output logic [FLIT_WIDTH*GATE_WIDTH-1:0] o_r_dt,
  output logic                             o_full,
  output logic                             o_drop
`ifdef RX_SOF_CHECK_EN
  ,
  output logic                             o_err_sof
`endif
);

  localparam int HEADER_SIZE  = 1 + 2 * GATE_WIDTH;
  localparam int HEADER_FLITS = (HEADER_SIZE + FLIT_WIDTH - 1) / FLIT_WIDTH;
  localparam int BEAT_WIDTH   = FLIT_WIDTH * GATE_FOLDS;
  localparam int DATA_WIDTH   = FLIT_WIDTH * GATE_WIDTH;
  localparam int MAX_BEATS    = (HEADER_FLITS + GATE_WIDTH + GATE_FOLDS - 1) / GATE_FOLDS;
  localparam int BW           = $clog2(MAX_BEATS + 1);
  localparam int AW           = $clog2(DEPTH);
  localparam int PW           = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DROP    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [BW-1:0]         nbeats_q, nbeats_d;
  logic [GATE_WIDTH-1:0] vl_q, vl_d;
  logic [GATE_WIDTH-1:0] cr_q, cr_d;
  logic [DATA_WIDTH-1:0] dt_q, dt_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [GATE_WIDTH-1:0] mem_vl_q [DEPTH];
  logic [GATE_WIDTH-1:0] mem_vl_d [DEPTH];
  logic [GATE_WIDTH-1:0] mem_cr_q [DEPTH];
  logic [GATE_WIDTH-1:0] mem_cr_d [DEPTH];
  logic [DATA_WIDTH-1:0] mem_dt_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_dt_d [DEPTH];

  logic [FLIT_WIDTH-1:0] slot_s [GATE_FOLDS];
  logic [GATE_WIDTH-1:0] hdr_vl_s, hdr_cr_s;
  logic [BW-1:0]         hdr_nbeats_s;
  logic                  in_idle_s;
  logic [BW-1:0]         beat_idx_s, cur_nbeats_s;
  logic [GATE_WIDTH-1:0] cur_vl_s, cur_cr_s;
  logic [DATA_WIDTH-1:0] base_dt_s, cap_dt_s;
  logic                  last_s, full_s, avail_s, pull_ok_s, accept_s;
  logic                  commit_s, drop_s;

  for (genvar k = 0; k < GATE_FOLDS; k++) begin : g_slot
    assign slot_s[k] = i_w_rx[FLIT_WIDTH*(GATE_FOLDS-k)-1 -: FLIT_WIDTH];
  end

  // Header fields sit at the top of the beat, directly below the one-flag.
  assign hdr_vl_s = i_w_rx[BEAT_WIDTH-2 -: GATE_WIDTH];
  assign hdr_cr_s = i_w_rx[BEAT_WIDTH-2-GATE_WIDTH -: GATE_WIDTH];

  assign avail_s   = (wptr_q != rptr_q);
  assign full_s    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pull_ok_s = i_r_pull && avail_s;

`ifdef RX_SOF_CHECK_EN
  logic hdr_flag_s;
  assign hdr_flag_s = i_w_rx[BEAT_WIDTH-1];
  assign accept_s   = (!full_s || pull_ok_s) && hdr_flag_s;
  assign o_err_sof  = (state_q == ST_IDLE) && i_w_enable && !hdr_flag_s;
`else
  assign accept_s   = !full_s || pull_ok_s;
`endif

  // Packet length in beats, derived from the header valids.
  always_comb begin
    int pop;
    pop = 0;
    for (int g = 0; g < GATE_WIDTH; g++) begin
      pop = pop + (hdr_vl_s[g] ? 1 : 0);
    end
    hdr_nbeats_s = BW'((HEADER_FLITS + pop + GATE_FOLDS - 1) / GATE_FOLDS);
  end

  // A header beat presents its own fields; later beats use the captured ones.
  assign in_idle_s    = (state_q == ST_IDLE);
  assign beat_idx_s   = in_idle_s ? {BW{1'b0}} : beat_q;
  assign cur_nbeats_s = in_idle_s ? hdr_nbeats_s : nbeats_q;
  assign cur_vl_s     = in_idle_s ? hdr_vl_s : vl_q;
  assign cur_cr_s     = in_idle_s ? hdr_cr_s : cr_q;
  assign base_dt_s    = in_idle_s ? {DATA_WIDTH{1'b0}} : dt_q;
  assign last_s       = (int'(beat_idx_s) + 1 == int'(cur_nbeats_s));

  // Route payload flits to lanes. A valid gate with rank r among the valid
  // gates takes stream flit HEADER_FLITS+r, so it captures from this beat
  // only when that flit index falls inside the beat.
  always_comb begin
    int rank;
    int fidx;
    int beat_base;
    cap_dt_s  = base_dt_s;
    rank      = 0;
    fidx      = 0;
    beat_base = int'(beat_idx_s) * GATE_FOLDS;
    for (int g = 0; g < GATE_WIDTH; g++) begin
      fidx = HEADER_FLITS + rank;
      for (int k = 0; k < GATE_FOLDS; k++) begin
        cap_dt_s[g*FLIT_WIDTH +: FLIT_WIDTH] = (cur_vl_s[g] && (fidx == beat_base + k)) ?
            slot_s[k] : cap_dt_s[g*FLIT_WIDTH +: FLIT_WIDTH];
      end
      rank = rank + (cur_vl_s[g] ? 1 : 0);
    end
  end

  // Receive FSM: next state, beat bookkeeping, commit and drop decisions.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    nbeats_d = nbeats_q;
    vl_d     = vl_q;
    cr_d     = cr_q;
    dt_d     = dt_q;
    commit_s = 1'b0;
    drop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_w_enable) begin
          vl_d     = hdr_vl_s;
          cr_d     = hdr_cr_s;
          dt_d     = cap_dt_s;
          nbeats_d = hdr_nbeats_s;
          beat_d   = BW'(1);
          if (last_s) begin
            commit_s = accept_s;
            drop_s   = !accept_s;
          end else begin
            state_d = accept_s ? ST_COLLECT : ST_DROP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        dt_d   = cap_dt_s;
        beat_d = beat_q + BW'(1);
        if (last_s) begin
          commit_s = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_DROP: begin
        beat_d = beat_q + BW'(1);
        if (last_s) begin
          drop_s  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Queue write port and pointer update; a commit and a pull may coincide.
  always_comb begin
    mem_vl_d = mem_vl_q;
    mem_cr_d = mem_cr_q;
    mem_dt_d = mem_dt_q;
    if (commit_s) begin
      mem_vl_d[wptr_q[AW-1:0]] = cur_vl_s;
      mem_cr_d[wptr_q[AW-1:0]] = cur_cr_s;
      mem_dt_d[wptr_q[AW-1:0]] = cap_dt_s;
    end else begin
      mem_vl_d[wptr_q[AW-1:0]] = mem_vl_q[wptr_q[AW-1:0]];
    end
    wptr_d = wptr_q + PW'(commit_s);
    rptr_d = rptr_q + PW'(pull_ok_s);
  end

  // State, packet assembly and queue registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= ST_IDLE;
      beat_q   <= {BW{1'b0}};
      nbeats_q <= {BW{1'b0}};
      vl_q     <= {GATE_WIDTH{1'b0}};
      cr_q     <= {GATE_WIDTH{1'b0}};
      dt_q     <= {DATA_WIDTH{1'b0}};
      wptr_q   <= {PW{1'b0}};
      rptr_q   <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_vl_q[i] <= {GATE_WIDTH{1'b0}};
        mem_cr_q[i] <= {GATE_WIDTH{1'b0}};
        mem_dt_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      nbeats_q <= nbeats_d;
      vl_q     <= vl_d;
      cr_q     <= cr_d;
      dt_q     <= dt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      mem_vl_q <= mem_vl_d;
      mem_cr_q <= mem_cr_d;
      mem_dt_q <= mem_dt_d;
    end
  end

  assign o_r_available = avail_s;
  assign o_full        = full_s;
  assign o_drop        = drop_s;
  assign o_r_vl        = avail_s ? mem_vl_q[rptr_q[AW-1:0]] : {GATE_WIDTH{1'b0}};
  assign o_r_cr        = avail_s ? mem_cr_q[rptr_q[AW-1:0]] : {GATE_WIDTH{1'b0}};
  assign o_r_dt        = avail_s ? mem_dt_q[rptr_q[AW-1:0]] : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_link_receiver.sv
// Bench for link_receiver with default parameters (8-bit flits, 4 gates,
// 2 flits per beat, 4-entry queue). Packets are built as flit lists from
// their fields, and an expected-packet queue stands in for the DUT queue.
module tb_link_receiver;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]  vl;
    logic [3:0]  cr;
    logic [31:0] dt;
  } pkt_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_w_enable = 1'b0;
  logic [15:0] i_w_rx = 16'h0000;
  logic        i_r_pull = 1'b0;
  logic        o_r_available;
  logic [3:0]  o_r_vl;
  logic [3:0]  o_r_cr;
  logic [31:0] o_r_dt;
  logic        o_full;
  logic        o_drop;
`ifdef RX_SOF_CHECK_EN
  logic        o_err_sof;
`endif

  pkt_t mq[$];
  int   checks = 0;
  int   errors = 0;

  link_receiver dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_w_enable    (i_w_enable),
    .i_w_rx        (i_w_rx),
    .i_r_pull      (i_r_pull),
    .o_r_available (o_r_available),
    .o_r_vl        (o_r_vl),
    .o_r_cr        (o_r_cr),
    .o_r_dt        (o_r_dt),
    .o_full        (o_full),
    .o_drop        (o_drop)
`ifdef RX_SOF_CHECK_EN
    ,
    .o_err_sof     (o_err_sof)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Head-of-queue outputs against the expected queue.
  task automatic check_head();
    if (mq.size() == 0) begin
      chk("avail", o_r_available, 32'd0);
      chk("vl_empty", o_r_vl, 32'd0);
      chk("cr_empty", o_r_cr, 32'd0);
      chk("dt_empty", o_r_dt, 32'd0);
    end else begin
      chk("avail", o_r_available, 32'd1);
      chk("vl", o_r_vl, mq[0].vl);
      chk("cr", o_r_cr, mq[0].cr);
      chk("dt", o_r_dt, mq[0].dt);
    end
    chk("full", o_full, mq.size() == DEPTH);
  endtask

  // One clock: apply inputs, check outputs mid-cycle, advance past the edge.
  task automatic tick(input logic en, input logic [15:0] rx, input logic pull,
                      input logic exp_drop, input logic exp_err);
    logic pull_ok;
    i_w_enable = en;
    i_w_rx     = rx;
    i_r_pull   = pull;
    #1;
    check_head();
    chk("drop", o_drop, exp_drop);
`ifdef RX_SOF_CHECK_EN
    chk("err_sof", o_err_sof, exp_err);
`endif
    pull_ok = pull && (mq.size() > 0);
    @(posedge i_clk);
    #1;
    if (pull_ok) void'(mq.pop_front());
  endtask

  task automatic idle(input logic pull);
    tick(1'b0, 16'($urandom), pull, 1'b0, 1'b0);
  endtask

  // pull_mode: 0 never pull, 1 pull on the header beat only, 2 random pulls.
  // Payload flit j is pay[31-8j -: 8].
  task automatic send_pkt(input logic [3:0] vl, input logic [3:0] cr, input logic flag,
                          input logic [6:0] lo, input logic [31:0] pay, input int pull_mode);
    logic [7:0]  fl[$];
    logic [15:0] hw;
    pkt_t        p;
    int          j;
    int          nb;
    logic        acc;
    logic        pull;
    logic        last;
    logic        err;
    hw = {flag, vl, cr, lo};
    fl.push_back(hw[15:8]);
    fl.push_back(hw[7:0]);
    p.vl = vl;
    p.cr = cr;
    p.dt = 32'h0;
    j = 0;
    for (int g = 0; g < 4; g++) begin
      if (vl[g]) begin
        fl.push_back(pay[31-8*j -: 8]);
        p.dt[8*g +: 8] = pay[31-8*j -: 8];
        j++;
      end
    end
    while (fl.size() % 2 != 0) fl.push_back(8'($urandom));
    nb  = fl.size() / 2;
    acc = 1'b0;
    for (int b = 0; b < nb; b++) begin
      pull = (pull_mode == 1) ? (b == 0) :
             (pull_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (b == 0) begin
        acc = (mq.size() < DEPTH) || (pull && (mq.size() > 0));
`ifdef RX_SOF_CHECK_EN
        if (!flag) acc = 1'b0;
`endif
      end
      err = 1'b0;
`ifdef RX_SOF_CHECK_EN
      err = (b == 0) && !flag;
`endif
      last = (b == nb - 1);
      tick((b == 0) ? 1'b1 : 1'($urandom_range(0, 1)), {fl[2*b], fl[2*b+1]},
           pull, last && !acc, err);
      if (last && acc) mq.push_back(p);
    end
  endtask

  task automatic do_reset();
    i_rst      = 1'b0;
    i_w_enable = 1'b0;
    i_w_rx     = 16'h0000;
    i_r_pull   = 1'b0;
    mq.delete();
    @(posedge i_clk);
    #1;
    check_head();
    chk("rst_drop", o_drop, 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
  endtask

  initial begin
    do_reset();

    // Normal two-beat packet: 0xA980 then 0x1122.
    send_pkt(4'b0101, 4'b0011, 1'b1, 7'h00, 32'h11220000, 0);
    chk("norm_avail", o_r_available, 32'd1);
    chk("norm_vl", o_r_vl, 32'h5);
    chk("norm_cr", o_r_cr, 32'h3);
    chk("norm_dt", o_r_dt, 32'h00220011);
    idle(1'b1);
    chk("norm_popped", o_r_available, 32'd0);

    // Header-only packet 0x8780.
    send_pkt(4'b0000, 4'b1111, 1'b1, 7'h00, 32'h0, 0);
    chk("hdr_avail", o_r_available, 32'd1);
    chk("hdr_vl", o_r_vl, 32'h0);
    chk("hdr_cr", o_r_cr, 32'hF);
    chk("hdr_dt", o_r_dt, 32'h0);
    idle(1'b1);
    idle(1'b1);

    // Overflow: fill, drop a fifth (three beats), pull once, accept a sixth.
    do_reset();
    for (int i = 0; i < 4; i++)
      send_pkt(4'($urandom), 4'($urandom), 1'b1, 7'($urandom), $urandom, 0);
    chk("ovf_full", o_full, 32'd1);
    send_pkt(4'b1111, 4'b1001, 1'b1, 7'h15, 32'hDEADBEEF, 0);
    chk("ovf_still_full", o_full, 32'd1);
    idle(1'b1);
    chk("ovf_after_pull", o_full, 32'd0);
    send_pkt(4'b0110, 4'b0101, 1'b1, 7'h00, 32'hA5C30000, 0);
    chk("ovf_sixth_full", o_full, 32'd1);

    // Single-beat packet arriving while full with a pull on its header beat.
    send_pkt(4'b0000, 4'b1010, 1'b1, 7'h3C, 32'h0, 1);
    chk("fullpull_full", o_full, 32'd1);
    repeat (4) idle(1'b1);
    chk("fullpull_drained", o_r_available, 32'd0);

    // Reset in the middle of a two-beat packet, then a fresh packet.
    do_reset();
    tick(1'b1, 16'hA980, 1'b0, 1'b0, 1'b0);
    do_reset();
    send_pkt(4'b1000, 4'b0110, 1'b1, 7'h00, 32'h5A000000, 0);
    chk("rstmid_vl", o_r_vl, 32'h8);
    chk("rstmid_cr", o_r_cr, 32'h6);
    chk("rstmid_dt", o_r_dt, 32'h5A000000);
    idle(1'b1);
    chk("rstmid_single", o_r_available, 32'd0);

`ifdef RX_SOF_CHECK_EN
    // Header 0x2980 has its one-flag clear.
    do_reset();
    send_pkt(4'b0101, 4'b0011, 1'b0, 7'h00, 32'h11220000, 0);
    chk("sof_empty", o_r_available, 32'd0);
`endif

    // Randomized traffic with random pulls and idle gaps.
    do_reset();
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) idle(1'($urandom_range(0, 1)));
      send_pkt(4'($urandom), 4'($urandom), ($urandom_range(0, 7) != 0),
               7'($urandom), $urandom, 2);
    end
    repeat (6) idle(1'b1);
    chk("final_empty", o_r_available, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
